inst_fetch: RTL

Instruction fetch stage sitting directly upstream of the 32 x 20-bit instruction memory. It owns the program counter, drives the memory's read port, absorbs the memory's one-cycle registered read latency, and delivers instructions with their PC to decode over a valid/ready handshake. It supports branch redirects, and optionally halts fetch on a halt opcode.

---
 rtl/inst_fetch_if.sv | 30 +++
 rtl/inst_fetch.sv | 97 +++++++++
 2 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, decode valid/ready handshake
// and branch redirect, bundled for the inst_fetch ports.
interface inst_fetch_if #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 20
);
  logic              imem_enable;
  logic              imem_read_writenot;
  logic [ADDR_W-1:0] imem_read_address;
  logic [INST_W-1:0] imem_data;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              fetch_halted;

  modport master (
    output imem_enable, imem_read_writenot, imem_read_address,
    output inst_out, inst_pc, inst_valid, fetch_halted,
    input  imem_data, inst_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_enable, imem_read_writenot, imem_read_address,
    input  inst_out, inst_pc, inst_valid, fetch_halted,
    output imem_data, inst_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, one-cycle imem latency absorption, 2-entry FIFO to decode,
// branch redirect. Optional halt-opcode stop under FETCH_HALT_DETECT_EN.
module inst_fetch #(
  parameter int                ADDR_W   = 5,
  parameter int                INST_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  entry_t [1:0]      fifo_q, fifo_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              squash_q, squash_d;
  logic              halted_q, halted_d;
  logic              post_rst_q;

  logic              out_vld, pop, push, issue, halt_det;
  logic [1:0]        occ, keep;

  assign out_vld = !rst && (count_q != 2'd0);
  assign pop     = out_vld && bus.inst_ready;
  // occupancy the FIFO is committed to after this cycle's pop, counting the owed response
  assign occ     = count_q - {1'b0, pop} + {1'b0, inflight_q};
  assign push    = inflight_q && !squash_q && !bus.branch_taken;
  assign issue   = !rst && !post_rst_q && !bus.branch_taken && !halted_q && (occ < 2'd2);

`ifdef FETCH_HALT_DETECT_EN
  assign halt_det = push && (bus.imem_data[INST_W-1 -: 4] == 4'hF);
`else
  assign halt_det = 1'b0;
`endif

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    fifo_d        = fifo_q;
    keep          = count_q - {1'b0, pop};
    inflight_d    = issue;
    squash_d      = issue && halt_det;
    halted_d      = halted_q || halt_det;

    if (pop) fifo_d[0] = fifo_q[1];
    if (push) fifo_d[keep[0]] = {bus.imem_data, inflight_pc_q};
    count_d = keep + {1'b0, push};

    if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_pc_d = pc_q;
    end

    // a pop in the branch cycle has already completed; everything behind it is dropped
    if (bus.branch_taken) begin
      count_d  = 2'd0;
      pc_d     = bus.branch_target;
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fifo_q        <= '0;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
      halted_q      <= 1'b0;
      post_rst_q    <= 1'b1;
    end else begin
      pc_q          <= pc_d;
      fifo_q        <= fifo_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
      halted_q      <= halted_d;
      post_rst_q    <= 1'b0;
    end
  end

  assign bus.imem_enable        = issue;
  assign bus.imem_read_writenot = 1'b1;
  assign bus.imem_read_address  = issue ? pc_q : '0;
  assign bus.inst_valid         = out_vld;
  assign bus.inst_out           = out_vld ? fifo_q[0].inst : '0;
  assign bus.inst_pc            = out_vld ? fifo_q[0].pc : '0;
  assign bus.fetch_halted       = !rst && halted_q;
endmodule
